// File: rtl/pwm_pkg.sv
// Shared PWM-domain definitions: duty width, default period length, sequencer states
// and the linear-step / gamma helper functions.
package pwm_pkg;

    localparam int DUTY_W                    = 8;
    localparam int PWM_PERIOD_CYCLES_DEFAULT = 500000;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

    // Move cur toward tgt by min(step, |tgt - cur|); the 9-bit math cannot overshoot or wrap.
    function automatic duty_t step_toward(input duty_t cur, input duty_t tgt, input duty_t step);
        logic [DUTY_W:0] diff;
        logic [DUTY_W:0] delta;
        logic [DUTY_W:0] res;
        diff  = (tgt >= cur) ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
        delta = ({1'b0, step} < diff) ? {1'b0, step} : diff;
        res   = (tgt >= cur) ? ({1'b0, cur} + delta) : ({1'b0, cur} - delta);
        return duty_t'(res);
    endfunction

    // Quadratic perceptual curve; the +255 rounding keeps 255 mapped to 255.
    function automatic duty_t gamma_map(input duty_t lin);
        logic [2*DUTY_W-1:0] sq;
        sq = {{DUTY_W{1'b0}}, lin} * {{DUTY_W{1'b0}}, lin} + 16'd255;
        return duty_t'(sq >> DUTY_W);
    endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter with a registered tick on the last clk of each period.
module pwm_period_timer
    import pwm_pkg::*;
#(
    parameter int PERIOD_CYCLES = PWM_PERIOD_CYCLES_DEFAULT,
    parameter int CNT_W         = 19
) (
    input  logic clk,
    input  logic rst_n,
    output logic period_tick
);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PERIOD_CYCLES - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // The tick is registered, so it is raised one count early to coincide with LAST.
    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_q == PRE_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign period_tick = tick_q;

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Linear duty-cycle fader for the PWM generator; updates land only on period boundaries.
// Optional PWM_FADE_GAMMA_EN adds a registered quadratic mapping on the duty output.
module pwm_fade_sequencer
    import pwm_pkg::*;
#(
    parameter int PERIOD_CYCLES = PWM_PERIOD_CYCLES_DEFAULT,
    parameter int CNT_W         = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [DUTY_W-1:0] cmd_step,
    input  logic [DUTY_W-1:0] cmd_periods,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              period_tick,
    output logic              busy,
    output logic              done
);

    state_e state_q, state_d;
    duty_t  lin_q, lin_d;
    duty_t  tgt_q, tgt_d;
    duty_t  step_q, step_d;
    duty_t  per_q, per_d;
    duty_t  ivl_q, ivl_d;
    logic   done_q, done_d;
    logic   busy_q, busy_d;
    logic   ready_q, ready_d;
    duty_t  next_lin;

    pwm_period_timer #(
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .period_tick (period_tick)
    );

    assign next_lin = step_toward(lin_q, tgt_q, step_q);

    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        lin_d   = lin_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        per_d   = per_q;
        ivl_d   = ivl_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        ready_d = ready_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    tgt_d  = cmd_target;
                    step_d = (cmd_step == '0)    ? duty_t'(1) : cmd_step;
                    per_d  = (cmd_periods == '0) ? duty_t'(1) : cmd_periods;
                    ivl_d  = '0;
                    if (cmd_target != lin_q) begin
                        state_d = RAMP;
                        busy_d  = 1'b1;
                        ready_d = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RAMP: begin
                // Abort takes priority over an update due on the same tick.
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else if (period_tick) begin
                    if (ivl_q == per_q - 1'b1) begin
                        lin_d = next_lin;
                        ivl_d = '0;
                        if (next_lin == tgt_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            ready_d = 1'b1;
                        end
                    end else begin
                        ivl_d = ivl_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lin_q   <= '0;
            tgt_q   <= '0;
            step_q  <= duty_t'(1);
            per_q   <= duty_t'(1);
            ivl_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            lin_q   <= lin_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            per_q   <= per_d;
            ivl_q   <= ivl_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign busy      = busy_q;
    assign cmd_ready = ready_q;

`ifdef PWM_FADE_GAMMA_EN
    duty_t duty_q, duty_d;
    logic  done_out_q, done_out_d;

    // done is delayed alongside the mapped duty so both appear in the same cycle.
    always_comb begin
        duty_d     = gamma_map(lin_q);
        done_out_d = done_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q     <= '0;
            done_out_q <= 1'b0;
        end else begin
            duty_q     <= duty_d;
            done_out_q <= done_out_d;
        end
    end

    assign duty_cycle = duty_q;
    assign done       = done_out_q;
`else
    assign duty_cycle = lin_q;
    assign done       = done_q;
`endif

endmodule
